// File: rtl/counter_read_arbiter_pkg.sv
// Shared types and widths for the counter read arbiter.
// The requester count default lives here so the interface and top agree on it.
package counter_read_arbiter_pkg;

    localparam int CNT_W         = 32;
    localparam int DATA_W        = 64;
    localparam int N_REQ_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        BEAT_A,
        BEAT_B,
        WAIT_B,
        RESP
    } state_t;

endpackage

// File: rtl/counter_read_arbiter_if.sv
// Requester-side and counter-side signals of the counter read arbiter.
// rd_req_i is a level held until its own rd_valid_o pulse; cnt_ack_i answers each cnt_req_o beat one cycle later.
interface counter_read_arbiter_if
    import counter_read_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) ();

    logic [N_REQ-1:0]  rd_req_i;
    logic [N_REQ-1:0]  rd_valid_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_err_o;
    logic              cnt_req_o;
    logic              cnt_atomic_o;
    logic              cnt_ack_i;
    logic [CNT_W-1:0]  cnt_count_i;
    logic              busy_o;

    modport master (
        output rd_req_i, cnt_ack_i, cnt_count_i,
        input  rd_valid_o, rd_data_o, rd_err_o, cnt_req_o, cnt_atomic_o, busy_o
    );

    modport slave (
        input  rd_req_i, cnt_ack_i, cnt_count_i,
        output rd_valid_o, rd_data_o, rd_err_o, cnt_req_o, cnt_atomic_o, busy_o
    );

endinterface

// File: rtl/counter_read_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after ptr, wrapping N_REQ-1 -> 0.
module counter_read_arbiter_rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int               j;
    logic [IDX_W-1:0] jj;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            jj = IDX_W'(j);
            if (!valid && req[jj]) begin
                valid     = 1'b1;
                grant[jj] = 1'b1;
                idx       = jj;
            end
        end
    end

endmodule

// File: rtl/counter_read_arbiter.sv
// Arbitrates N_REQ requesters onto one 32-bit counter port and assembles
// a 64-bit value from two acknowledged beats, one read per five cycles.
module counter_read_arbiter
    import counter_read_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    counter_read_arbiter_if.slave  bus,
    output state_t                 dbg_state
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_oh;
    logic             err;
    logic [CNT_W-1:0] data_lo;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;

    counter_read_arbiter_rr_arbiter #(.N_REQ(N_REQ)) rr_arbiter (
        .req   (bus.rd_req_i),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            grant_idx        <= '0;
            grant_oh         <= '0;
            err              <= 1'b0;
            data_lo          <= '0;
            bus.rd_valid_o   <= '0;
            bus.rd_data_o    <= '0;
            bus.rd_err_o     <= 1'b0;
            bus.cnt_req_o    <= 1'b0;
            bus.cnt_atomic_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_idx        <= arb_idx;
                        grant_oh         <= arb_grant;
                        data_lo          <= '0;
                        err              <= 1'b0;
                        bus.cnt_req_o    <= 1'b1;
                        bus.cnt_atomic_o <= 1'b1;
                        state            <= BEAT_A;
                    end
                end
                BEAT_A: begin
                    bus.cnt_atomic_o <= 1'b0;
                    state            <= BEAT_B;
                end
                BEAT_B: begin
                    // This ack answers the BEAT_A request: lower half.
                    bus.cnt_req_o <= 1'b0;
                    if (bus.cnt_ack_i) data_lo <= bus.cnt_count_i;
                    else               err     <= 1'b1;
                    state <= WAIT_B;
                end
                WAIT_B: begin
                    bus.rd_valid_o <= grant_oh;
                    bus.rd_data_o  <= {(bus.cnt_ack_i ? bus.cnt_count_i : {CNT_W{1'b0}}), data_lo};
                    bus.rd_err_o   <= err | ~bus.cnt_ack_i;
                    state          <= RESP;
                end
                RESP: begin
                    bus.rd_valid_o <= '0;
                    rr_ptr         <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    err            <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o = (state != IDLE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_counter_read_arbiter.sv
// Directed and randomized transactions against a transaction-level model of
// the round-robin counter read arbiter.
module tb_counter_read_arbiter;
    import counter_read_arbiter_pkg::*;

    localparam int N = 4;

    logic   clk   = 1'b0;
    logic   reset = 1'b0;
    state_t dbg_state;

    counter_read_arbiter_if #(.N_REQ(N)) bus ();

    counter_read_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          exp_ptr     = 0;
    logic [63:0] last_data   = '0;
    logic        last_err    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first set bit at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic stray_ack();
        bus.cnt_ack_i   = 1'($urandom_range(0, 1));
        bus.cnt_count_i = $urandom;
    endtask

    task automatic apply_reset();
        reset         = 1'b0;
        bus.rd_req_i  = '0;
        bus.cnt_ack_i = 1'b0;
        bus.cnt_count_i = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", bus.rd_valid_o, 0);
        check("rst_data", bus.rd_data_o, 0);
        check("rst_err", bus.rd_err_o, 0);
        check("rst_cnt_req", bus.cnt_req_o, 0);
        check("rst_atomic", bus.cnt_atomic_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        reset     = 1'b1;
        exp_ptr   = 0;
        last_data = '0;
        last_err  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            bus.rd_req_i    = '0;
            bus.cnt_ack_i   = 1'b1;
            bus.cnt_count_i = $urandom;
            @(negedge clk);
            check("idle_busy", bus.busy_o, 0);
            check("idle_valid", bus.rd_valid_o, 0);
            check("idle_err_held", bus.rd_err_o, last_err);
            check("idle_data_held", bus.rd_data_o, last_data);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the next idle negedge.
    task automatic txn(input logic [N-1:0] req, input bit ack_a, input bit ack_b,
                       input logic [31:0] da, input logic [31:0] db, input bit hold);
        int          g;
        logic [63:0] ed;
        logic        ee;
        logic [N-1:0] onehot;
        check("pre_busy", bus.busy_o, 0);
        check("pre_valid", bus.rd_valid_o, 0);
        check("pre_data_held", bus.rd_data_o, last_data);
        check("pre_err_held", bus.rd_err_o, last_err);
        bus.rd_req_i = req;
        stray_ack();
        g = pick(req, exp_ptr);
        @(negedge clk);
        check("beat_a_req", bus.cnt_req_o, 1);
        check("beat_a_atomic", bus.cnt_atomic_o, 1);
        check("beat_a_busy", bus.busy_o, 1);
        check("beat_a_valid", bus.rd_valid_o, 0);
        if (!hold) bus.rd_req_i = N'($urandom);
        stray_ack();
        @(negedge clk);
        check("beat_b_req", bus.cnt_req_o, 1);
        check("beat_b_atomic", bus.cnt_atomic_o, 0);
        bus.cnt_ack_i   = ack_a;
        bus.cnt_count_i = ack_a ? da : $urandom;
        @(negedge clk);
        check("wait_b_req", bus.cnt_req_o, 0);
        check("wait_b_atomic", bus.cnt_atomic_o, 0);
        check("wait_b_valid", bus.rd_valid_o, 0);
        bus.cnt_ack_i   = ack_b;
        bus.cnt_count_i = ack_b ? db : $urandom;
        @(negedge clk);
        ed     = {(ack_b ? db : 32'h0), (ack_a ? da : 32'h0)};
        ee     = !(ack_a && ack_b);
        onehot = '0;
        onehot[g] = 1'b1;
        check("resp_valid", bus.rd_valid_o, onehot);
        check("resp_data", bus.rd_data_o, ed);
        check("resp_err", bus.rd_err_o, ee);
        check("resp_busy", bus.busy_o, 1);
        check("resp_cnt_req", bus.cnt_req_o, 0);
        stray_ack();
        last_data = ed;
        last_err  = ee;
        exp_ptr   = (g + 1) % N;
        @(negedge clk);
    endtask

    // Start a read, then pull reset low while the upper beat is outstanding.
    task automatic txn_reset(input logic [N-1:0] req);
        bus.rd_req_i = req;
        stray_ack();
        @(negedge clk);
        check("abort_beat_a", bus.cnt_req_o, 1);
        @(negedge clk);
        bus.cnt_ack_i   = 1'b1;
        bus.cnt_count_i = $urandom;
        @(negedge clk);
        reset           = 1'b0;
        bus.cnt_ack_i   = 1'b1;
        bus.cnt_count_i = $urandom;
        @(negedge clk);
        check("abort_valid", bus.rd_valid_o, 0);
        check("abort_data", bus.rd_data_o, 0);
        check("abort_err", bus.rd_err_o, 0);
        check("abort_cnt_req", bus.cnt_req_o, 0);
        check("abort_atomic", bus.cnt_atomic_o, 0);
        check("abort_busy", bus.busy_o, 0);
        reset         = 1'b1;
        bus.cnt_ack_i = 1'b0;
        exp_ptr       = 0;
        last_data     = '0;
        last_err      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        apply_reset();

        // Single read from requester 0.
        txn(4'b0001, 1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0002, 1'b0);

        // Stray acks while idle.
        idle_cycles(3);

        // Continuous load from reset: 0,1,2,3,0 back to back.
        apply_reset();
        for (int t = 0; t < 5; t++)
            txn(4'b1111, 1'b1, 1'b1, $urandom, $urandom, 1'b1);

        // Pointer at 2 with requesters 1 and 3 pending: 3 first, then 1.
        txn(4'b0010, 1'b1, 1'b1, $urandom, $urandom, 1'b1);
        txn(4'b1010, 1'b1, 1'b1, $urandom, $urandom, 1'b1);
        txn(4'b1010, 1'b1, 1'b1, $urandom, $urandom, 1'b1);

        // Missing acks on each half and on both.
        txn(4'b0100, 1'b1, 1'b0, 32'hCAFE_1234, 32'hDEAD_BEEF, 1'b0);
        txn(4'b0100, 1'b0, 1'b1, 32'h1111_2222, 32'h3333_4444, 1'b0);
        txn(4'b1000, 1'b0, 1'b0, 32'h5555_6666, 32'h7777_8888, 1'b0);
        txn(4'b1111, 1'b1, 1'b1, 32'h89AB_CDEF, 32'h0123_4567, 1'b0);

        // Abort in WAIT_B, then the held request re-arbitrates from pointer 0.
        txn(4'b0010, 1'b1, 1'b1, $urandom, $urandom, 1'b1);
        txn_reset(4'b1010);
        txn(4'b1010, 1'b1, 1'b1, $urandom, $urandom, 1'b1);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            r = N'($urandom_range(0, 15));
            if (r == '0)
                idle_cycles(1);
            else
                txn(r, $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                    $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_read_arbiter.md
COUNTER_READ_ARBITER -- requirements
Module: counter_read_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the counter read port (2..8).
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 rd_req_i  input  N_REQ  per-requester 64-bit read request; level, held until own rd_valid_o.
REQ-005 rd_valid_o  output  N_REQ  one-hot, one-cycle response pulse to granted requester.
REQ-006 rd_data_o  output  64  assembled counter value, valid with rd_valid_o.
REQ-007 rd_err_o  output  1  missing-ack flag, valid with rd_valid_o.
REQ-008 cnt_req_o  output  1  read request to counter.
REQ-009 cnt_atomic_o  output  1  marks first beat of a two-beat read.
REQ-010 cnt_ack_i  input  1  counter acknowledge, expected one cycle after cnt_req_o.
REQ-011 cnt_count_i  input  32  counter data, valid with cnt_ack_i.
REQ-012 busy_o  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, BEAT_A, BEAT_B, WAIT_B, RESP.
REQ-014 IDLE: if any rd_req_i bit set, grant the first set bit at or after rr_ptr (round-robin, wrapping N_REQ-1 -> 0), register grant index, go BEAT_A; else stay.
REQ-015 BEAT_A: cnt_req_o=1, cnt_atomic_o=1; go BEAT_B.
REQ-016 BEAT_B: cnt_req_o=1, cnt_atomic_o=0; sample cnt_ack_i; if 1, capture cnt_count_i into data[31:0], else set err; go WAIT_B.
REQ-017 WAIT_B: cnt_req_o=0; sample cnt_ack_i; if 1, capture cnt_count_i into data[63:32], else set err; go RESP.
REQ-018 RESP: rd_valid_o[grant]=1, rd_data_o=captured 64-bit value, rd_err_o=err; rr_ptr <= (grant+1) mod N_REQ; clear err; go IDLE.
REQ-019 Outside RESP, rd_valid_o SHALL be 0 and rd_data_o/rd_err_o SHALL hold last values.
REQ-020 Outside BEAT_A/BEAT_B, cnt_req_o and cnt_atomic_o SHALL be 0; cnt_atomic_o never 1 without cnt_req_o.
REQ-021 Request-to-response latency SHALL be exactly 4 cycles from grant cycle (IDLE) to RESP; one read per 5 cycles under continuous load.
REQ-022 A data beat missing its ack SHALL leave that 32-bit half as 0x0000_0000 for this transaction.
REQ-023 cnt_ack_i in IDLE, BEAT_A or RESP SHALL be ignored.
REQ-024 rd_req_i changes outside IDLE SHALL not affect the transaction in flight; a requester dropping its request mid-transaction still receives rd_valid_o.
REQ-025 Simultaneous requests: exactly one granted per IDLE; every persistently-requesting requester served within N_REQ transactions.

Reset
REQ-026 reset low at a clock edge SHALL force IDLE, rr_ptr=0, err=0, captured data=0, grant=0 from the next cycle.
REQ-027 Outputs after reset: rd_valid_o=0, rd_data_o=0, rd_err_o=0, cnt_req_o=0, cnt_atomic_o=0, busy_o=0.
REQ-028 Reset mid-transaction SHALL abort with no rd_valid_o pulse; the aborted requester re-arbitrates normally.

Structure
REQ-029 Shared package SHALL hold the FSM state enum, CNT_W=32, DATA_W=64 and the default N_REQ.
REQ-030 Round-robin grant logic SHALL be one sub-module, rr_arbiter (request vector + pointer in, one-hot grant + index out).
REQ-031 Output cnt_* and rd_* signals SHALL be driven from registered state with no combinational path from rd_req_i.

Verification
REQ-032 Single read: rd_req_i=0001, counter acks 0x0000_00FF then 0x0000_0002 -> cnt_req_o 2 cycles (atomic 1 then 0), rd_valid_o=0001 4 cycles after grant, rd_data_o=0x00000002_000000FF, rd_err_o=0.
REQ-033 All requesters hold rd_req_i=1111 from reset -> grants in order 0,1,2,3,0, one rd_valid_o every 5 cycles.
REQ-034 Requesters 1 and 3 pending, rr_ptr=2 -> requester 3 served first, then 1.
REQ-035 Second ack suppressed -> rd_valid_o pulses, rd_err_o=1, rd_data_o[63:32]=0, lower half correct.
REQ-036 reset asserted in WAIT_B -> no rd_valid_o, outputs zero next cycle, held request re-served with rr_ptr=0 order.
REQ-037 Stray cnt_ack_i pulses in IDLE -> no state change, no rd_valid_o, rd_err_o unchanged.
